// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller.
package hazard_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  // Instruction word injected into IF/ID on a flush
  localparam logic [31:0] NOP = 32'h0;

  // Pipeline control bundle, MSB first: PC write, IF/ID write, IF flush, ID/EX bubble
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = ctrl_t'(4'b1100);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(4'b0000);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(4'b1011);
  localparam ctrl_t CTRL_STALL  = ctrl_t'(4'b0001);
  localparam ctrl_t CTRL_HALT   = ctrl_t'(4'b0001);

  // Load in EX writes a register the ID instruction reads; r0 never hazards
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles, sticking at all-ones
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                   count <= '0;
    else if (en && (count != '1)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory
// freezes and halt, plus saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       inIdRs,
  input  logic [4:0]       inIdRt,
  input  logic             inExMemRead,
  input  logic [4:0]       inExRt,
  input  logic             inBranchTaken,
  input  logic             inMemBusy,
  input  logic             inHalt,
  output logic             outPcWrite,
  output logic             outIF_IDWrite,
  output logic             outIF_Flush,
  output logic             outID_EX_Bubble,
  output logic [CNT_W-1:0] outStallCount,
  output logic [CNT_W-1:0] outFlushCount
);

  state_t state, state_nxt;
  logic   pend_flush, pend_flush_nxt;
  // Set for the cycle after a load-use stall so one hazard costs one cycle
  logic   lu_stalled, lu_stalled_nxt;
  logic   lu;
  ctrl_t  ctrl;

  // State, pending-flush and stall-guard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_flush <= 1'b0;
      lu_stalled <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_flush <= pend_flush_nxt;
      lu_stalled <= lu_stalled_nxt;
    end
  end

  // Next state and control outputs. WAIT with memory ready behaves like RUN
  // for that cycle, so a branch remembered during the freeze flushes
  // immediately as the pipeline thaws.
  always_comb begin
    ctrl           = CTRL_NORMAL;
    state_nxt      = state;
    pend_flush_nxt = pend_flush;
    lu_stalled_nxt = 1'b0;
    lu             = load_use(inExMemRead, inExRt, inIdRs, inIdRt) && !lu_stalled;

    if (state == HALT) begin
      ctrl = CTRL_HALT;
    end else if (inHalt) begin
      ctrl           = CTRL_HALT;
      state_nxt      = HALT;
      pend_flush_nxt = 1'b0;
    end else if (inMemBusy) begin
      ctrl           = CTRL_FREEZE;
      state_nxt      = WAIT;
      pend_flush_nxt = pend_flush | inBranchTaken;
    end else begin
      state_nxt = RUN;
      if (inBranchTaken || pend_flush) begin
        ctrl           = CTRL_FLUSH;
        pend_flush_nxt = 1'b0;
      end else if (lu) begin
        ctrl           = CTRL_STALL;
        lu_stalled_nxt = 1'b1;
      end
    end

    // Reset presents the free-running controls regardless of inputs
    if (!rst_n) ctrl = CTRL_NORMAL;
  end

  assign outPcWrite      = ctrl.pc_write;
  assign outIF_IDWrite   = ctrl.if_id_write;
  assign outIF_Flush     = ctrl.if_flush;
  assign outID_EX_Bubble = ctrl.id_ex_bubble;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (!ctrl.pc_write),
    .count (outStallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (ctrl.if_flush),
    .count (outFlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor on
// the falling edge pops and compares them. A second instance with 4-bit
// counters shares all inputs to exercise saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       ex_mem_read = 1'b0, br = 1'b0, busy = 1'b0, halt = 1'b0;

  logic        pcw, ifidw, flush, bubble;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pcw, s_ifidw, s_flush, s_bubble;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  typedef struct {
    string    name;
    bit [3:0] ctrl;
    int       stall;
    int       flush;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .inIdRs(id_rs), .inIdRt(id_rt),
    .inExMemRead(ex_mem_read), .inExRt(ex_rt), .inBranchTaken(br),
    .inMemBusy(busy), .inHalt(halt),
    .outPcWrite(pcw), .outIF_IDWrite(ifidw), .outIF_Flush(flush),
    .outID_EX_Bubble(bubble), .outStallCount(stall_cnt), .outFlushCount(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .inIdRs(id_rs), .inIdRt(id_rt),
    .inExMemRead(ex_mem_read), .inExRt(ex_rt), .inBranchTaken(br),
    .inMemBusy(busy), .inHalt(halt),
    .outPcWrite(s_pcw), .outIF_IDWrite(s_ifidw), .outIF_Flush(s_flush),
    .outID_EX_Bubble(s_bubble), .outStallCount(s_stall_cnt), .outFlushCount(s_flush_cnt)
  );

  // Monitor: one expectation per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit [3:0] act, act_s;
      int es, ef;
      e     = q.pop_front();
      act   = {pcw, ifidw, flush, bubble};
      act_s = {s_pcw, s_ifidw, s_flush, s_bubble};
      es    = (e.stall > 15) ? 15 : e.stall;
      ef    = (e.flush > 15) ? 15 : e.flush;
      checks++;
      if (act !== e.ctrl || act_s !== e.ctrl || int'(stall_cnt) != e.stall ||
          int'(flush_cnt) != e.flush || int'(s_stall_cnt) != es || int'(s_flush_cnt) != ef) begin
        errors++;
        $display("FAIL %s: ctrl=%b small_ctrl=%b stall=%0d flush=%0d small_stall=%0d small_flush=%0d, want ctrl=%b stall=%0d flush=%0d small_stall=%0d small_flush=%0d",
                 e.name, act, act_s, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                 e.ctrl, e.stall, e.flush, es, ef);
      end
    end
  end

  // One pipeline cycle: drive inputs just after the edge and queue the expectation
  task automatic cyc(input string name, input bit rst,
                     input bit [4:0] rs, input bit [4:0] rt, input bit mr, input bit [4:0] ert,
                     input bit b, input bit bz, input bit h,
                     input bit [3:0] ectrl, input int es, input int ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
    br = b; busy = bz; halt = h;
    e.name = name; e.ctrl = ectrl; e.stall = es; e.flush = ef;
    q.push_back(e);
  endtask

  task automatic idle(input string name, input bit [3:0] ectrl, input int es, input int ef);
    cyc(name, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ectrl, es, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset forces free-running controls even with busy/halt/branch asserted
    cyc("reset_state", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 4'b1100, 0, 0);
    idle("idle", 4'b1100, 0, 0);
    // Load-use via rs; hazard inputs held two cycles still cost one stall
    cyc("lu_rs_stall", 1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0001, 0, 0);
    cyc("lu_rs_once",  1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 4'b1100, 1, 0);
    idle("lu_cnt", 4'b1100, 1, 0);
    // r0 load never hazards
    cyc("lu_r0", 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1, 0);
    idle("lu_r0_cnt", 4'b1100, 1, 0);
    // Load-use via rt
    cyc("lu_rt_stall", 1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 4'b0001, 1, 0);
    idle("lu_rt_cnt", 4'b1100, 2, 0);
    // Matching register but not a load
    cyc("no_load", 1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 4'b1100, 2, 0);
    // Branch overrides a coincident load-use
    cyc("br_over_lu", 1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 4'b1011, 2, 0);
    idle("br_cnt", 4'b1100, 2, 1);
    // Memory busy three cycles, branch in the second -> flush on thaw
    cyc("busy1", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 2, 1);
    cyc("busy2_br", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 3, 1);
    cyc("busy3", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 4, 1);
    idle("thaw_flush", 4'b1011, 5, 1);
    idle("after_thaw", 4'b1100, 5, 2);
    // Two branches during a freeze produce a single flush
    cyc("busy_a", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 5, 2);
    cyc("busy_b_br", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 6, 2);
    cyc("busy_c_br", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 7, 2);
    idle("thaw_flush2", 4'b1011, 8, 2);
    idle("one_flush", 4'b1100, 8, 3);
    // Branch arrives with busy in RUN, then halt in WAIT drops the pending flush
    cyc("busy_br_run", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 8, 3);
    cyc("halt_in_wait", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0001, 9, 3);
    // HALT held; branch and busy are ignored
    for (int i = 0; i < 10; i++)
      cyc("halt_hold", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, (i == 3), (i == 5), 1'b0, 4'b0001, 10 + i, 3);
    // Asynchronous reset mid-cycle out of HALT
    cyc("rst_mid_halt", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 0, 0);
    idle("run_after_rst", 4'b1100, 0, 0);
    // Reset during a freeze with a pending branch: no flush afterwards
    cyc("busy_br_pre", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 0, 0);
    cyc("rst_mid_wait", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 0, 0);
    idle("no_pend_flush", 4'b1100, 0, 0);
    // 20 busy cycles: the 4-bit instance saturates at 15
    for (int i = 0; i < 20; i++)
      cyc("busy_sat", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000, i, 0);
    idle("sat_final", 4'b1100, 20, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 clk  input  1  pipeline clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 inIdRs  input  5  rs field of the instruction in ID.
REQ-005 inIdRt  input  5  rt field of the instruction in ID.
REQ-006 inExMemRead  input  1  instruction in EX is a load.
REQ-007 inExRt  input  5  destination register of the load in EX.
REQ-008 inBranchTaken  input  1  branch/jump resolved taken this cycle; single-cycle pulse.
REQ-009 inMemBusy  input  1  data memory not ready; whole pipeline must freeze.
REQ-010 inHalt  input  1  halt instruction reached WB.
REQ-011 outPcWrite  output  1  PC register update enable.
REQ-012 outIF_IDWrite  output  1  IF/ID latch write enable.
REQ-013 outIF_Flush  output  1  IF/ID latch flush; instruction field forced to 0 (NOP).
REQ-014 outID_EX_Bubble  output  1  zero ID/EX control fields.
REQ-015 outStallCount  output  CNT_W  cycles with outPcWrite=0, saturating.
REQ-016 outFlushCount  output  CNT_W  cycles with outIF_Flush=1, saturating.

Function
REQ-017 FSM states: RUN, WAIT, HALT; control outputs are combinational from the current state, pendFlush and the current inputs.
REQ-018 Load-use hazard: loadUse = inExMemRead && inExRt!=0 && (inExRt==inIdRs || inExRt==inIdRt).
REQ-019 RUN priority, highest first: inHalt, inMemBusy, inBranchTaken, pendFlush, loadUse, normal.
REQ-020 RUN, inHalt=1: outPcWrite=0, outIF_IDWrite=0, outID_EX_Bubble=1, outIF_Flush=0; next state HALT.
REQ-021 RUN, inMemBusy=1: outPcWrite=0, outIF_IDWrite=0, outIF_Flush=0, outID_EX_Bubble=0; next state WAIT; pendFlush<=inBranchTaken.
REQ-022 RUN, inBranchTaken=1: outPcWrite=1, outIF_IDWrite=0, outIF_Flush=1, outID_EX_Bubble=1; a coincident loadUse is ignored.
REQ-023 RUN, pendFlush=1: same outputs as REQ-022; pendFlush<=0.
REQ-024 RUN, loadUse=1: outPcWrite=0, outIF_IDWrite=0, outIF_Flush=0, outID_EX_Bubble=1; exactly one stall cycle per hazard.
REQ-025 RUN, normal: outPcWrite=1, outIF_IDWrite=1, outIF_Flush=0, outID_EX_Bubble=0.
REQ-026 WAIT: all four control outputs 0 while inMemBusy=1; inBranchTaken=1 sets pendFlush.
REQ-027 WAIT exits to RUN the cycle after inMemBusy=0 is sampled; inHalt in WAIT goes to HALT and clears pendFlush.
REQ-028 HALT: outPcWrite=0, outIF_IDWrite=0, outIF_Flush=0, outID_EX_Bubble=1; exit only via reset.
REQ-029 outStallCount increments when outPcWrite=0, outFlushCount when outIF_Flush=1; both hold at 2^CNT_W-1 and never wrap.
REQ-030 pendFlush is set by at most one branch; a second branch during WAIT leaves it at 1.

Reset
REQ-031 While rst_n=0: state=RUN, pendFlush=0, both counters 0, independent of clk.
REQ-032 Control outputs during reset equal RUN-normal values (1,1,0,0); release mid-stall resumes RUN with no pending flush.

Structure
REQ-033 Shared package holds the state encoding (RUN=2'd0, WAIT=2'd1, HALT=2'd2) and the NOP constant 32'h0.
REQ-034 One sub-module, sat_counter (CNT_W, enable, async active-low clear), instantiated twice.

Verification
REQ-035 Load rt=5 in EX, ID rs=5 -> one cycle PcWrite=0, IF_IDWrite=0, Bubble=1; next cycle all normal; StallCount=1.
REQ-036 Load rt=0 in EX, ID rs=0 -> no stall; StallCount stays 0.
REQ-037 Branch taken with loadUse same cycle -> IF_Flush=1, PcWrite=1, Bubble=1; FlushCount=1, StallCount=0.
REQ-038 MemBusy 3 cycles, branch pulse in cycle 2 -> 3 frozen cycles, then one IF_Flush=1 cycle, then normal.
REQ-039 inHalt pulse -> HALT held 10 cycles (PcWrite=0, Bubble=1); rst_n low mid-cycle -> outputs 1,1,0,0 immediately, counters 0.
REQ-040 CNT_W=4, MemBusy held 20 cycles -> StallCount stops at 15.
